// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the enums used by the slave return-path mux.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Which source owns the current data phase.
    typedef enum logic [2:0] {
        DSEL_PORT0   = 3'd0,
        DSEL_PORT1   = 3'd1,
        DSEL_PORT2   = 3'd2,
        DSEL_PORT3   = 3'd3,
        DSEL_DEFAULT = 3'd4,
        DSEL_NONE    = 3'd5
    } dsel_e;

    // Default-slave two-cycle ERROR sequencer.
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // Address-phase selection: lowest-numbered enabled select wins; an
    // active transfer with no select goes to the default slave.
    function automatic dsel_e dsel_select(input logic [3:0] sel, input logic active);
        dsel_e res;
        if (sel[0]) begin
            res = DSEL_PORT0;
        end else if (sel[1]) begin
            res = DSEL_PORT1;
        end else if (sel[2]) begin
            res = DSEL_PORT2;
        end else if (sel[3]) begin
            res = DSEL_PORT3;
        end else if (active) begin
            res = DSEL_DEFAULT;
        end else begin
            res = DSEL_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_lite_slave_mux_if.sv
// Bus-side signals of the slave return-path mux: master transfer type,
// decoder selects, per-port slave responses and the muxed return path.
interface ahb_lite_slave_mux_if;

    logic [1:0]  HTRANS;
    logic        P0_HSEL;
    logic        P1_HSEL;
    logic        P2_HSEL;
    logic        P3_HSEL;
    logic        P0_HREADYOUT;
    logic        P1_HREADYOUT;
    logic        P2_HREADYOUT;
    logic        P3_HREADYOUT;
    logic        P0_HRESP;
    logic        P1_HRESP;
    logic        P2_HRESP;
    logic        P3_HRESP;
    logic [31:0] P0_HRDATA;
    logic [31:0] P1_HRDATA;
    logic [31:0] P2_HRDATA;
    logic [31:0] P3_HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HTRANS,
        input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        output HREADY, HRESP, HRDATA
    );

    modport master (
        output HTRANS,
        output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        input  HREADY, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_lite_default_slave.sv
// Built-in default slave: answers unmapped transfers with the two-cycle
// AHB ERROR response (HREADY low then high, HRESP high in both cycles).
module ahb_lite_default_slave
    import ahb_lite_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic HREADY,
    input  logic def_capture,
    output logic HREADYOUT,
    output logic HRESP
);

    ds_state_e state_q;
    ds_state_e state_d;
    logic      capture_s;

    // A default transfer is only accepted when the bus completes the address phase.
    assign capture_s = HREADY & def_capture;

    // State register with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ERR2 can chain straight into another ERR1 for back-to-back misses.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: begin
                if (capture_s) begin
                    state_d = DS_ERR1;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: begin
                if (capture_s) begin
                    state_d = DS_ERR1;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            default: state_d = DS_IDLE;
        endcase
    end

    // Response outputs depend on state only, keeping HREADY free of loops.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            DS_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_slave_mux.sv
// AHB-Lite return-path mux: remembers the address-phase selection and routes
// the selected slave's ready/response/data back to the master in the data phase.
module ahb_lite_slave_mux
    import ahb_lite_pkg::*;
#(
    parameter bit PORT0_EN = 1'b1,
    parameter bit PORT1_EN = 1'b1,
    parameter bit PORT2_EN = 1'b0,
    parameter bit PORT3_EN = 1'b1
)(
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_slave_mux_if.slave  bus
);

    logic [3:0]  sel_s;
    logic        trans_active_s;
    dsel_e       addr_sel_s;
    dsel_e       dsel_q;
    dsel_e       dsel_d;
    logic        def_capture_s;
    logic        ds_hreadyout_s;
    logic        ds_hresp_s;
    logic        hready_s;
    logic        hresp_s;
    logic [31:0] hrdata_s;

    // A disabled port's select is masked so its region falls to the default slave.
    assign sel_s = {bus.P3_HSEL & PORT3_EN, bus.P2_HSEL & PORT2_EN,
                    bus.P1_HSEL & PORT1_EN, bus.P0_HSEL & PORT0_EN};
    assign trans_active_s = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    assign addr_sel_s     = dsel_select(sel_s, trans_active_s);
    assign def_capture_s  = (addr_sel_s == DSEL_DEFAULT);

    // Capture the address-phase selection only when the previous transfer completes.
    always_comb begin
        dsel_d = dsel_q;
        if (hready_s) begin
            dsel_d = addr_sel_s;
        end else begin
            dsel_d = dsel_q;
        end
    end

    // Data-phase select register with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_q <= DSEL_NONE;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    ahb_lite_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HREADY      (hready_s),
        .def_capture (def_capture_s),
        .HREADYOUT   (ds_hreadyout_s),
        .HRESP       (ds_hresp_s)
    );

    // Data-phase return mux; mapped slaves pass through with no added latency.
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = HRESP_OKAY;
        hrdata_s = 32'h0000_0000;
        case (dsel_q)
            DSEL_PORT0: begin
                hready_s = bus.P0_HREADYOUT;
                hresp_s  = bus.P0_HRESP;
                hrdata_s = bus.P0_HRDATA;
            end
            DSEL_PORT1: begin
                hready_s = bus.P1_HREADYOUT;
                hresp_s  = bus.P1_HRESP;
                hrdata_s = bus.P1_HRDATA;
            end
            DSEL_PORT2: begin
                hready_s = bus.P2_HREADYOUT;
                hresp_s  = bus.P2_HRESP;
                hrdata_s = bus.P2_HRDATA;
            end
            DSEL_PORT3: begin
                hready_s = bus.P3_HREADYOUT;
                hresp_s  = bus.P3_HRESP;
                hrdata_s = bus.P3_HRDATA;
            end
            DSEL_DEFAULT: begin
                hready_s = ds_hreadyout_s;
                hresp_s  = ds_hresp_s;
                hrdata_s = 32'h0000_0000;
            end
            DSEL_NONE: begin
                hready_s = 1'b1;
                hresp_s  = HRESP_OKAY;
                hrdata_s = 32'h0000_0000;
            end
            default: begin
                hready_s = 1'b1;
                hresp_s  = HRESP_OKAY;
                hrdata_s = 32'h0000_0000;
            end
        endcase
    end

    assign bus.HREADY = hready_s;
    assign bus.HRESP  = hresp_s;
    assign bus.HRDATA = hrdata_s;

endmodule

// File: tb/tb_ahb_lite_slave_mux.sv
// Self-checking bench for ahb_lite_slave_mux: directed scenarios plus random
// traffic compared against a transaction-level model of the return path.
module tb_ahb_lite_slave_mux;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    ahb_lite_slave_mux_if bus();

    ahb_lite_slave_mux dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Port enables of the default-parameter DUT, bit k = port k.
    localparam logic [3:0] PORT_EN_MASK = 4'b1011;
    localparam int TGT_ERR  = 4;
    localparam int TGT_NONE = 5;

    // Stimulus for the current cycle.
    logic        drv_rst;
    logic [1:0]  drv_trans;
    logic [3:0]  drv_hsel;
    logic [3:0]  drv_rdy;
    logic [3:0]  drv_resp;
    logic [31:0] drv_data [4];

    // Model: who owns the current data phase, and which error cycle (1 or 2).
    int m_tgt;
    int m_err_cycle;

    logic        obs_ready;
    logic        obs_resp;
    logic [31:0] obs_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        drv_rst     = 1'b0;
        drv_trans   = 2'b00;
        drv_hsel    = 4'b0000;
        drv_rdy     = 4'b1111;
        drv_resp    = 4'b0000;
        drv_data[0] = 32'hA0A0_A0A0;
        drv_data[1] = 32'hB1B1_B1B1;
        drv_data[2] = 32'h2222_2222;
        drv_data[3] = 32'h1234_5678;
    endtask

    // Drive one cycle (entered at negedge), check against model, advance model.
    task automatic cycle(input string tag);
        logic        e_ready;
        logic        e_resp;
        logic [31:0] e_data;
        int          k_new;
        HRESET           = drv_rst;
        bus.HTRANS       = drv_trans;
        bus.P0_HSEL      = drv_hsel[0];
        bus.P1_HSEL      = drv_hsel[1];
        bus.P2_HSEL      = drv_hsel[2];
        bus.P3_HSEL      = drv_hsel[3];
        bus.P0_HREADYOUT = drv_rdy[0];
        bus.P1_HREADYOUT = drv_rdy[1];
        bus.P2_HREADYOUT = drv_rdy[2];
        bus.P3_HREADYOUT = drv_rdy[3];
        bus.P0_HRESP     = drv_resp[0];
        bus.P1_HRESP     = drv_resp[1];
        bus.P2_HRESP     = drv_resp[2];
        bus.P3_HRESP     = drv_resp[3];
        bus.P0_HRDATA    = drv_data[0];
        bus.P1_HRDATA    = drv_data[1];
        bus.P2_HRDATA    = drv_data[2];
        bus.P3_HRDATA    = drv_data[3];
        #1;
        obs_ready = bus.HREADY;
        obs_resp  = bus.HRESP;
        obs_data  = bus.HRDATA;
        if (m_tgt < TGT_ERR) begin
            e_ready = drv_rdy[m_tgt];
            e_resp  = drv_resp[m_tgt];
            e_data  = drv_data[m_tgt];
        end else if (m_tgt == TGT_ERR) begin
            e_ready = (m_err_cycle == 2);
            e_resp  = 1'b1;
            e_data  = 32'h0;
        end else begin
            e_ready = 1'b1;
            e_resp  = 1'b0;
            e_data  = 32'h0;
        end
        check_eq({tag, "/hready"}, {31'h0, obs_ready}, {31'h0, e_ready});
        check_eq({tag, "/hresp"},  {31'h0, obs_resp},  {31'h0, e_resp});
        check_eq({tag, "/hrdata"}, obs_data, e_data);
        if (drv_rst) begin
            m_tgt       = TGT_NONE;
            m_err_cycle = 0;
        end else if (e_ready) begin
            k_new = TGT_NONE;
            for (int k = 3; k >= 0; k--) begin
                if (drv_hsel[k] && PORT_EN_MASK[k]) k_new = k;
            end
            if (k_new == TGT_NONE && (drv_trans == 2'b10 || drv_trans == 2'b11)) k_new = TGT_ERR;
            m_tgt       = k_new;
            m_err_cycle = 1;
        end else if (m_tgt == TGT_ERR) begin
            m_err_cycle = 2;
        end
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic expect_rr(input string tag, input logic rdy, input logic rsp);
        check_eq({tag, "/rdy_const"}, {31'h0, obs_ready}, {31'h0, rdy});
        check_eq({tag, "/rsp_const"}, {31'h0, obs_resp},  {31'h0, rsp});
    endtask

    initial begin
        set_idle();
        drv_rst = 1'b1;
        HRESET  = 1'b1;
        bus.HTRANS = 2'b00;
        {bus.P0_HSEL, bus.P1_HSEL, bus.P2_HSEL, bus.P3_HSEL} = 4'b0000;
        {bus.P0_HREADYOUT, bus.P1_HREADYOUT, bus.P2_HREADYOUT, bus.P3_HREADYOUT} = 4'b1111;
        {bus.P0_HRESP, bus.P1_HRESP, bus.P2_HRESP, bus.P3_HRESP} = 4'b0000;
        bus.P0_HRDATA = 32'h0; bus.P1_HRDATA = 32'h0;
        bus.P2_HRDATA = 32'h0; bus.P3_HRDATA = 32'h0;
        @(posedge HCLK);
        @(negedge HCLK);
        m_tgt       = TGT_NONE;
        m_err_cycle = 0;

        // Reset held two cycles, then released with no traffic.
        for (int i = 0; i < 4; i++) begin
            set_idle();
            drv_rst = (i < 2);
            cycle("reset");
            expect_rr("reset", 1'b1, 1'b0);
            check_eq("reset/data_const", obs_data, 32'h0);
        end

        // Mapped read on P1 with two wait states.
        set_idle(); drv_trans = 2'b10; drv_hsel = 4'b0010;
        cycle("p1_addr");
        set_idle(); drv_rdy[1] = 1'b0; drv_data[1] = 32'hDEAD_BEEF;
        cycle("p1_wait0");
        expect_rr("p1_wait0", 1'b0, 1'b0);
        check_eq("p1_wait0/no_p3", {31'h0, obs_data == 32'h1234_5678}, 32'h0);
        cycle("p1_wait1");
        expect_rr("p1_wait1", 1'b0, 1'b0);
        check_eq("p1_wait1/no_p3", {31'h0, obs_data == 32'h1234_5678}, 32'h0);
        drv_rdy[1] = 1'b1;
        cycle("p1_done");
        expect_rr("p1_done", 1'b1, 1'b0);
        check_eq("p1_done/data_const", obs_data, 32'hDEAD_BEEF);

        // Single unmapped transfer.
        set_idle(); drv_trans = 2'b10;
        cycle("unmap_addr");
        set_idle();
        cycle("unmap_c1"); expect_rr("unmap_c1", 1'b0, 1'b1);
        cycle("unmap_c2"); expect_rr("unmap_c2", 1'b1, 1'b1);
        cycle("unmap_c3"); expect_rr("unmap_c3", 1'b1, 1'b0);

        // Two back-to-back unmapped transfers (second held through ERR1).
        set_idle(); drv_trans = 2'b10;
        cycle("b2b_a");
        cycle("b2b_1"); expect_rr("b2b_1", 1'b0, 1'b1);
        cycle("b2b_2"); expect_rr("b2b_2", 1'b1, 1'b1);
        set_idle();
        cycle("b2b_3"); expect_rr("b2b_3", 1'b0, 1'b1);
        cycle("b2b_4"); expect_rr("b2b_4", 1'b1, 1'b1);

        // Unmapped transfer followed by a P0 transfer captured in ERR2.
        set_idle(); drv_trans = 2'b10;
        cycle("err_p0_a");
        drv_hsel = 4'b0001;
        cycle("err_p0_e1"); expect_rr("err_p0_e1", 1'b0, 1'b1);
        cycle("err_p0_e2"); expect_rr("err_p0_e2", 1'b1, 1'b1);
        set_idle(); drv_data[0] = 32'hCAFE_F00D;
        cycle("err_p0_d");
        expect_rr("err_p0_d", 1'b1, 1'b0);
        check_eq("err_p0_d/data_const", obs_data, 32'hCAFE_F00D);

        // IDLE transfer with no select: zero-wait OKAY.
        set_idle();
        cycle("idle_a");
        cycle("idle_d"); expect_rr("idle_d", 1'b1, 1'b0);

        // Disabled port 2: ERROR response, its data ignored.
        set_idle(); drv_trans = 2'b10; drv_hsel = 4'b0100;
        cycle("p2_addr");
        set_idle(); drv_data[2] = 32'h5A5A_5A5A;
        cycle("p2_c1"); expect_rr("p2_c1", 1'b0, 1'b1);
        check_eq("p2_c1/data_const", obs_data, 32'h0);
        cycle("p2_c2"); expect_rr("p2_c2", 1'b1, 1'b1);
        check_eq("p2_c2/data_const", obs_data, 32'h0);

        // Reset asserted while in ERR1.
        set_idle(); drv_trans = 2'b10;
        cycle("rst_e1_a");
        set_idle(); drv_rst = 1'b1;
        cycle("rst_e1_r"); expect_rr("rst_e1_r", 1'b0, 1'b1);
        set_idle();
        cycle("rst_e1_n"); expect_rr("rst_e1_n", 1'b1, 1'b0);
        drv_trans = 2'b10;
        cycle("rst_e1_x"); expect_rr("rst_e1_x", 1'b1, 1'b0);
        set_idle();
        cycle("rst_e1_y"); expect_rr("rst_e1_y", 1'b0, 1'b1);
        cycle("rst_e1_z"); expect_rr("rst_e1_z", 1'b1, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drv_rst   = ($urandom_range(0, 63) == 0);
            drv_trans = 2'($urandom_range(0, 3));
            drv_hsel  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            drv_rdy   = 4'($urandom | $urandom);
            drv_resp  = 4'($urandom & $urandom & $urandom);
            for (int k = 0; k < 4; k++) drv_data[k] = $urandom;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_mux.md
# ahb_lite_slave_mux

Return-path multiplexer for the AHB-Lite interconnect, including a built-in default slave. It tracks which port the decoder selected in each address phase and, in the following data phase, routes that port's HREADYOUT, HRESP and HRDATA back to the master. Transfers that hit no enabled port receive the standard two-cycle ERROR response from the internal default slave. It sits beside the address decoder, between the four slave ports (RAMCODE, RAMDATA, spare, UART) and the Cortex-M0 master.

## Interface
Parameters:
- PORT0_EN, 1, RAMCODE port enable; 0 masks P0_HSEL, so the region becomes unmapped
- PORT1_EN, 1, RAMDATA port enable
- PORT2_EN, 0, spare port enable
- PORT3_EN, 1, UART port enable

Ports:
- HCLK  in  1  bus clock; the only clock in the block
- HRESET  in  1  synchronous, active-high reset
- HTRANS  in  2  master transfer type; bit 1 set means NONSEQ or SEQ
- P0_HSEL..P3_HSEL  in  1 each  decoder selects for the current address phase
- P0_HREADYOUT..P3_HREADYOUT  in  1 each  slave ready
- P0_HRESP..P3_HRESP  in  1 each  slave response; 0 is OKAY, 1 is ERROR
- P0_HRDATA..P3_HRDATA  in  32 each  slave read data
- HREADY  out  1  muxed ready, driven to the master and fed back to every slave
- HRESP  out  1  muxed response
- HRDATA  out  32  muxed read data

## Operation
- Effective select: sel_k = Pk_HSEL & PORTk_EN.
- Address-phase capture happens on the HCLK edge where HREADY=1. The registered data-phase select dsel becomes one of:
  - PORTk, when sel_k=1. Priority is P0 > P1 > P2 > P3 if more than one select is high.
  - DEFAULT, when no sel_k is set and HTRANS[1]=1.
  - NONE, when no sel_k is set and HTRANS[1]=0 (IDLE or BUSY).
- No capture occurs while HREADY=0; dsel holds.
- Data-phase outputs:
  - dsel=PORTk: HREADY=Pk_HREADYOUT, HRESP=Pk_HRESP, HRDATA=Pk_HRDATA. These are combinational passthrough, so a slave's wait states and its two-cycle ERROR pass through unchanged.
  - dsel=NONE: HREADY=1, HRESP=0, HRDATA=0.
  - dsel=DEFAULT: the default-slave FSM drives the outputs and HRDATA=0.
- Default-slave FSM states are IDLE, ERR1 and ERR2.
  - IDLE: outputs HREADY=1, HRESP=0. Goes to ERR1 when a DEFAULT capture occurs.
  - ERR1: outputs HREADY=0, HRESP=1. Always goes to ERR2.
  - ERR2: outputs HREADY=1, HRESP=1. Goes to ERR1 if another DEFAULT capture occurs in this cycle, otherwise to IDLE.
- Back-to-back unmapped transfers therefore give ERR1, ERR2, ERR1, ERR2, and so on.
- A capture to PORTk or NONE made in ERR2 moves the FSM to IDLE, and dsel switches to that selection on the next cycle.
- Reset: dsel=NONE and FSM=IDLE. Outputs during and after reset are HREADY=1, HRESP=0, HRDATA=0.
- Reset asserted mid-transfer, including in ERR1, aborts the transfer. The reset values appear on the cycle after the reset edge.

## Timing
- Select and FSM state are updated only on the rising edge of HCLK.
- All outputs are combinational from dsel, the FSM state and the slave inputs. There is no added latency.
- A default-slave error occupies exactly 2 data-phase cycles. Its first cycle is the cycle after the address phase.
- Behaviour at mapped slaves adds zero extra cycles on top of the slave's own timing.

## Structure
- Package ahb_lite_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11
  - HRESP_OKAY and HRESP_ERROR
  - the data-select enum (PORT0..PORT3, DEFAULT, NONE)
  - the default-slave state enum
- Sub-module ahb_lite_default_slave contains the IDLE/ERR1/ERR2 FSM. Its inputs are HCLK, HRESET, HREADY and a "default capture" strobe. Its outputs are HREADYOUT and HRESP.
- The top level contains the capture register and the output mux.

## Test plan
- Reset check: assert HRESET for 2 cycles, then release with no traffic. Required: HREADY=1, HRESP=0, HRDATA=0 throughout.
- Mapped read with wait states: NONSEQ with P1_HSEL=1, P1_HREADYOUT low for 2 cycles, P1_HRDATA=32'hDEAD_BEEF.
  - HREADY must read 0, 0, 1, with HRDATA=32'hDEAD_BEEF on the final cycle.
  - P3_HRDATA=32'h1234_5678 held constant must never appear on HRDATA.
- Unmapped transfer: NONSEQ with all HSEL=0. Required: cycle+1 gives HREADY=0, HRESP=1; cycle+2 gives HREADY=1, HRESP=1; cycle+3 gives HREADY=1, HRESP=0.
- Back-to-back and pipelined mixes:
  - Two consecutive unmapped NONSEQ give HREADY 0,1,0,1 and HRESP 1,1,1,1.
  - An unmapped transfer followed by a P0 transfer captured in ERR2 gives P0 data in the next cycle.
- Idle and disabled ports:
  - HTRANS=IDLE with no HSEL gives a zero-wait OKAY.
  - With PORT2_EN=0, NONSEQ with P2_HSEL=1 gives the two-cycle ERROR and P2_HRDATA is ignored.
- Reset in ERR1: unmapped NONSEQ, then assert HRESET in ERR1. The next cycle must give HREADY=1, HRESP=0, and the FSM must be IDLE.
